// File: rtl/fifo_pop_ctrl.sv
// Burst pop controller: pulls words from a FIFO in bursts of up to BURST_LEN and
// registers them for downstream. Optional saturating capture counter: POP_CTRL_STATS_EN.
module fifo_pop_ctrl #(
  parameter int DATA_SIZE = 12,
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic                 fifo_valid,
  input  logic [DATA_SIZE-1:0] fifo_data_out,
  input  logic                 dn_almost_full,
  output logic                 fifo_read,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 proto_error,
  output logic [7:0]           pop_count,
  output logic [1:0]           state_dbg
);

  // Handshake: fifo_read is a pop request that the FIFO answers with fifo_valid
  // one cycle later; data_valid is a one-cycle strobe with no ready, so the
  // downstream throttles only through dn_almost_full.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(BURST_LEN - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] burst_cnt;
  logic [3:0] burst_cnt_nxt;
  logic       pend;

  assign fifo_read = (state == READ) && !fifo_empty && !dn_almost_full;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= IDLE;
      burst_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Burst completion wins, then empty/disable, then backpressure.
  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (enable && !fifo_empty && !dn_almost_full) begin
          state_nxt     = READ;
          burst_cnt_nxt = 4'd0;
        end
      end
      READ: begin
        if (fifo_read) begin
          burst_cnt_nxt = burst_cnt + 4'd1;
        end
        if (fifo_read && (burst_cnt == LAST_CNT)) begin
          state_nxt = DRAIN;
        end else if (fifo_empty || !enable) begin
          state_nxt = DRAIN;
        end else if (dn_almost_full) begin
          state_nxt = STALL;
        end
      end
      STALL: begin
        if (!enable) begin
          state_nxt = DRAIN;
        end else if (!dn_almost_full) begin
          state_nxt = READ;
        end
      end
      DRAIN: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = 4'd0;
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = 4'd0;
      end
    endcase
  end

  // pend marks the cycle in which a requested word is due back from the FIFO.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pend <= 1'b0;
    end else begin
      pend <= fifo_read;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= fifo_valid;
      if (fifo_valid) begin
        data_out <= fifo_data_out;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      proto_error <= 1'b0;
    end else if (fifo_valid && !pend) begin
      proto_error <= 1'b1;
    end
  end

`ifdef POP_CTRL_STATS_EN
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pop_count <= 8'd0;
    end else if (fifo_valid && (pop_count != 8'hFF)) begin
      pop_count <= pop_count + 8'd1;
    end
  end
`else
  assign pop_count = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Directed bench for fifo_pop_ctrl: a vector table for single-cycle behaviour plus
// sequences for a 6-word burst with a FIFO model, mid-burst reset and the capture counter.
module tb_fifo_pop_ctrl;

  localparam int DW = 12;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
`ifdef POP_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_L;
  logic          enable;
  logic          fifo_empty;
  logic          fifo_valid;
  logic [DW-1:0] fifo_data_out;
  logic          dn_almost_full;
  logic          fifo_read;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          busy;
  logic          proto_error;
  logic [7:0]    pop_count;
  logic [1:0]    state_dbg;

  fifo_pop_ctrl #(.DATA_SIZE(DW), .BURST_LEN(4)) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .fifo_valid    (fifo_valid),
    .fifo_data_out (fifo_data_out),
    .dn_almost_full(dn_almost_full),
    .fifo_read     (fifo_read),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .busy          (busy),
    .proto_error   (proto_error),
    .pop_count     (pop_count),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic          empty;
    logic          afull;
    logic          valid;
    logic [DW-1:0] data;
    logic          rd;
    logic [1:0]    st;
    logic          dv;
    logic [DW-1:0] dout;
    logic          perr;
    logic          bsy;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            caps  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_pop(input int n);
    if (!STATS) return 32'd0;
    return (n > 255) ? 32'd255 : 32'(n);
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_L        = 1'b0;
    enable         = 1'b0;
    fifo_empty     = 1'b1;
    fifo_valid     = 1'b0;
    fifo_data_out  = '0;
    dn_almost_full = 1'b0;
    caps           = 0;
    #1;
    check("rst_perr", proto_error, 0);
    check("rst_state", state_dbg, S_IDLE);
    check("rst_pop", pop_count, 0);
    #1;
    reset_L = 1'b1;
  endtask

  initial begin : main
    logic [DW-1:0] mem[6];
    logic [19:0]   exp_rd_bits;
    logic [DW-1:0] pend_word;
    logic [31:0]   exp_w;
    int            cnt, ptr, dv_cnt, viol;
    bit            last_rd, rd;

    // Vector fields: en empty afull valid data | rd st dv dout perr busy
    vecs.push_back('{1, 0, 0, 0, 12'h000, 0, S_IDLE,  0, 12'h000, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 12'h000, 1, S_READ,  0, 12'h000, 0, 1});
    vecs.push_back('{1, 0, 0, 1, 12'h0A1, 1, S_READ,  0, 12'h000, 0, 1});
    vecs.push_back('{1, 1, 0, 1, 12'h0A2, 0, S_READ,  1, 12'h0A1, 0, 1});
    vecs.push_back('{1, 1, 0, 0, 12'h000, 0, S_DRAIN, 1, 12'h0A2, 0, 1});
    vecs.push_back('{1, 1, 0, 0, 12'h000, 0, S_IDLE,  0, 12'h0A2, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 12'h000, 0, S_IDLE,  0, 12'h0A2, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 12'h000, 1, S_READ,  0, 12'h0A2, 0, 1});
    vecs.push_back('{1, 0, 0, 1, 12'h0B1, 1, S_READ,  0, 12'h0A2, 0, 1});
    vecs.push_back('{1, 0, 1, 1, 12'h0B2, 0, S_READ,  1, 12'h0B1, 0, 1});
    vecs.push_back('{1, 0, 1, 0, 12'h000, 0, S_STALL, 1, 12'h0B2, 0, 1});
    vecs.push_back('{1, 0, 1, 0, 12'h000, 0, S_STALL, 0, 12'h0B2, 0, 1});
    vecs.push_back('{1, 0, 0, 0, 12'h000, 0, S_STALL, 0, 12'h0B2, 0, 1});
    vecs.push_back('{1, 0, 0, 0, 12'h000, 1, S_READ,  0, 12'h0B2, 0, 1});
    vecs.push_back('{1, 0, 0, 1, 12'h0B3, 1, S_READ,  0, 12'h0B2, 0, 1});
    vecs.push_back('{1, 0, 0, 1, 12'h0B4, 0, S_DRAIN, 1, 12'h0B3, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 12'h000, 0, S_IDLE,  1, 12'h0B4, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 12'h000, 0, S_IDLE,  0, 12'h0B4, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 12'h0C1, 0, S_IDLE,  0, 12'h0B4, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 12'h000, 0, S_IDLE,  1, 12'h0C1, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 12'h000, 0, S_IDLE,  0, 12'h0C1, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 12'h000, 0, S_IDLE,  0, 12'h0C1, 1, 0});
    vecs.push_back('{1, 0, 1, 0, 12'h000, 0, S_READ,  0, 12'h0C1, 1, 1});
    vecs.push_back('{0, 0, 1, 0, 12'h000, 0, S_STALL, 0, 12'h0C1, 1, 1});
    vecs.push_back('{0, 0, 0, 0, 12'h000, 0, S_DRAIN, 0, 12'h0C1, 1, 1});
    vecs.push_back('{0, 0, 0, 0, 12'h000, 0, S_IDLE,  0, 12'h0C1, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 12'h000, 0, S_IDLE,  0, 12'h0C1, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 12'h000, 1, S_READ,  0, 12'h0C1, 1, 1});
    vecs.push_back('{0, 0, 0, 1, 12'h0C2, 0, S_DRAIN, 0, 12'h0C1, 1, 1});
    vecs.push_back('{0, 0, 0, 0, 12'h000, 0, S_IDLE,  1, 12'h0C2, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 12'h000, 0, S_IDLE,  0, 12'h0C2, 1, 0});

    // Clock/reset
    reset_L        = 1'b0;
    enable         = 1'b0;
    fifo_empty     = 1'b1;
    fifo_valid     = 1'b0;
    fifo_data_out  = '0;
    dn_almost_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("por_rd", fifo_read, 0);
    check("por_dv", data_valid, 0);
    check("por_dout", data_out, 0);
    check("por_busy", busy, 0);
    check("por_perr", proto_error, 0);
    check("por_state", state_dbg, S_IDLE);
    check("por_pop", pop_count, 0);
    #2;
    reset_L = 1'b1;

    // Vector table
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      enable         = vecs[i].en;
      fifo_empty     = vecs[i].empty;
      dn_almost_full = vecs[i].afull;
      fifo_valid     = vecs[i].valid;
      fifo_data_out  = vecs[i].data;
      #1;
      check($sformatf("v%0d_rd", i), fifo_read, vecs[i].rd);
      check($sformatf("v%0d_state", i), state_dbg, vecs[i].st);
      check($sformatf("v%0d_dv", i), data_valid, vecs[i].dv);
      check($sformatf("v%0d_dout", i), data_out, vecs[i].dout);
      check($sformatf("v%0d_perr", i), proto_error, vecs[i].perr);
      check($sformatf("v%0d_busy", i), busy, vecs[i].bsy);
      check($sformatf("v%0d_pop", i), pop_count, exp_pop(caps));
      if (fifo_empty && fifo_read) check($sformatf("v%0d_rd_empty", i), fifo_read, 0);
      if (vecs[i].valid) caps++;
    end

    // proto_error was sticky through the table; reset must clear it
    do_reset();

    // Six-word FIFO, burst of 4 then 2; read pattern is cycles 1-4 and 7-8
    for (int k = 0; k < 6; k++) begin
      mem[k] = 12'h100 + 12'(k);
      exp_q.push_back(mem[k]);
    end
    exp_rd_bits = 20'h0019E;
    cnt = 6; ptr = 0; dv_cnt = 0; viol = 0; last_rd = 0; pend_word = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      enable         = 1'b1;
      dn_almost_full = 1'b0;
      fifo_valid     = last_rd;
      fifo_data_out  = last_rd ? pend_word : '0;
      fifo_empty     = (cnt == 0);
      #1;
      rd = fifo_read;
      check($sformatf("m%0d_rd", c), rd, exp_rd_bits[c]);
      if (rd && fifo_empty) viol++;
      if (data_valid) begin
        dv_cnt++;
        exp_w = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
        check($sformatf("m%0d_data", c), data_out, exp_w);
      end
      if (rd && cnt > 0) begin
        pend_word = mem[ptr];
        ptr++;
        cnt--;
      end
      last_rd = rd;
    end
    check("m_dv_count", dv_cnt, 6);
    check("m_rd_while_empty", viol, 0);
    check("m_sb_left", exp_q.size(), 0);
    check("m_perr", proto_error, 0);
    check("m_state", state_dbg, S_IDLE);

    // Asynchronous reset between edges while a word is in flight
    @(posedge clk);
    #1;
    enable = 1'b1; fifo_empty = 1'b0; dn_almost_full = 1'b0; fifo_valid = 1'b0;
    @(posedge clk);
    #2;
    check("mr_read_state", state_dbg, S_READ);
    check("mr_read_rd", fifo_read, 1);
    @(posedge clk);
    #1;
    fifo_valid = 1'b1; fifo_data_out = 12'h5A5; fifo_empty = 1'b1;
    #1;
    check("mr_inflight_state", state_dbg, S_READ);
    #1;
    reset_L = 1'b0;
    #1;
    check("mr_rd", fifo_read, 0);
    check("mr_dv", data_valid, 0);
    check("mr_dout", data_out, 0);
    check("mr_busy", busy, 0);
    check("mr_perr", proto_error, 0);
    check("mr_pop", pop_count, 0);
    check("mr_state", state_dbg, S_IDLE);
    #1;
    reset_L = 1'b1;
    enable  = 1'b0;
    @(posedge clk);
    #1;
    check("mr_orphan_perr", proto_error, 1);
    check("mr_orphan_state", state_dbg, S_IDLE);
    fifo_valid = 1'b0;

    // Capture counter: 300 captures saturate at 255 when enabled, else stay 0
    do_reset();
    @(posedge clk);
    #1;
    fifo_valid    = 1'b1;
    fifo_data_out = 12'h3C3;
    repeat (10) @(posedge clk);
    #1;
    check("pop_10", pop_count, exp_pop(10));
    repeat (290) @(posedge clk);
    #1;
    check("pop_300", pop_count, exp_pop(300));
    fifo_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pop_hold", pop_count, exp_pop(300));
    check("pop_dv_end", data_valid, 0);
    check("pop_dout", data_out, 12'h3C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_pop_ctrl.md
FIFO_POP_CTRL -- requirements
Module: fifo_pop_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 12, the width of a FIFO data word.
REQ-002 SHALL have parameter BURST_LEN, default 4, the maximum number of reads per burst (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_L, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: permits new bursts to start.
REQ-006 SHALL have port fifo_empty, input, 1 bit: the FIFO empty flag.
REQ-007 SHALL have port fifo_valid, input, 1 bit: the FIFO read-data-valid strobe.
REQ-008 SHALL have port fifo_data_out, input, DATA_SIZE bits: the FIFO read data.
REQ-009 SHALL have port dn_almost_full, input, 1 bit: downstream backpressure.
REQ-010 SHALL have port fifo_read, output, 1 bit: the FIFO pop request.
REQ-011 SHALL have port data_out, output, DATA_SIZE bits: the captured word.
REQ-012 SHALL have port data_valid, output, 1 bit: data_out is valid this cycle.
REQ-013 SHALL have port busy, output, 1 bit: the FSM is not in IDLE.
REQ-014 SHALL have port proto_error, output, 1 bit: sticky protocol-violation flag.
REQ-015 SHALL have port pop_count, output, 8 bits: count of captured words.

Function
REQ-016 SHALL implement FSM states IDLE, READ, STALL, DRAIN, encoded in 2 bits.
REQ-017 SHALL drive fifo_read = (state==READ) & !fifo_empty & !dn_almost_full, combinationally; fifo_read is never 1 while fifo_empty=1.
REQ-018 SHALL go IDLE->READ when enable & !fifo_empty & !dn_almost_full, with burst_cnt=0.
REQ-019 SHALL, in READ, increment burst_cnt on each cycle where fifo_read=1.
REQ-020 SHALL go READ->DRAIN when fifo_read=1 & burst_cnt==BURST_LEN-1.
REQ-021 SHALL go READ->DRAIN when fifo_empty=1, or when enable=0; this check has priority over the stall condition.
REQ-022 SHALL go READ->STALL when dn_almost_full=1 and the REQ-021 conditions are absent.
REQ-023 SHALL go STALL->READ when dn_almost_full=0, keeping burst_cnt.
REQ-024 SHALL go STALL->DRAIN when enable=0.
REQ-025 SHALL leave DRAIN for IDLE after exactly one cycle, clearing burst_cnt.
REQ-026 SHALL set register pend=1 in each cycle following a fifo_read=1 cycle, and pend=0 otherwise.
REQ-027 SHALL, on fifo_valid=1, register data_out<=fifo_data_out and data_valid<=1; otherwise data_valid<=0 and data_out holds its value.
REQ-028 SHALL give latency: fifo_read in cycle N, FIFO data valid in N+1, data_valid=1 in N+2.
REQ-029 SHALL set proto_error=1 when fifo_valid=1 & pend=0; it stays 1 until reset.
REQ-030 SHALL drive busy=1 in READ, STALL and DRAIN.

Reset
REQ-031 SHALL, on reset_L=0 and asynchronously, force state=IDLE, burst_cnt=0, pend=0, data_out=0, data_valid=0, proto_error=0 and pop_count=0; fifo_read=0 follows.
REQ-032 SHALL, on reset mid-burst, discard any in-flight FIFO word; after release, the first fifo_valid without pend sets proto_error.

Configuration
REQ-033 SHALL, with macro POP_CTRL_STATS_EN defined, increment pop_count on each capture of REQ-027, saturating at 255.
REQ-034 SHALL, without POP_CTRL_STATS_EN, tie pop_count to 0 and infer no counter logic.

Verification
REQ-035 SHALL verify this scenario: FIFO holds 6 words, BURST_LEN=4, enable=1 -> fifo_read high for 4 consecutive cycles, DRAIN, IDLE, then 2 more reads; 6 data_valid pulses in order.
REQ-036 SHALL verify this scenario: FIFO holds 2 words -> fifo_read high 2 cycles, never while fifo_empty=1, READ->DRAIN on empty, proto_error=0.
REQ-037 SHALL verify this scenario: dn_almost_full=1 after read #2 of a burst for 3 cycles -> STALL for 3 cycles, fifo_read=0, then exactly 2 more reads finish the burst.
REQ-038 SHALL verify this scenario: drive fifo_valid=1 with no prior read -> proto_error=1 the next cycle, held until reset_L=0.
REQ-039 SHALL verify this scenario: reset_L low mid-READ, between clock edges -> all outputs 0 immediately, state IDLE.
REQ-040 SHALL verify this scenario: with POP_CTRL_STATS_EN, capture 300 words -> pop_count=255; without the macro, pop_count=0 throughout.
